// File: rtl/issue_reg_read.sv
// Issue/register-read stage: captures operands (with CDB bypass) into a 2-entry
// ordered buffer that feeds the execution unit, with branch kill/clear and flush.
module issue_reg_read #(
  parameter int PREG_IDX_W    = 6,
  parameter int ROB_IDX_W     = 5,
  parameter int EBR_MASK_SIZE = 4,
  parameter int CDB_WIDTH     = 2,
  parameter int PAYLOAD_W     = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            iq_valid,
  output logic                            iq_ready,
  input  logic [PREG_IDX_W-1:0]           iq_prs1_s,
  input  logic [PREG_IDX_W-1:0]           iq_prs2_s,
  input  logic [PREG_IDX_W-1:0]           iq_prd_s,
  input  logic [ROB_IDX_W-1:0]            iq_rob_id,
  input  logic [EBR_MASK_SIZE-1:0]        iq_ebr_mask,
  input  logic [PAYLOAD_W-1:0]            iq_payload,
  output logic [PREG_IDX_W-1:0]           rf_rs1_addr,
  output logic [PREG_IDX_W-1:0]           rf_rs2_addr,
  input  logic [31:0]                     rf_rs1_data,
  input  logic [31:0]                     rf_rs2_data,
  input  logic [CDB_WIDTH-1:0]            cdb_valid,
  input  logic [CDB_WIDTH*PREG_IDX_W-1:0] cdb_prd_s,
  input  logic [CDB_WIDTH*32-1:0]         cdb_data,
  input  logic                            bra_done,
  input  logic                            bra_mispredict,
  input  logic [EBR_MASK_SIZE-1:0]        bra_id,
  input  logic                            late_flush,
  output logic                            eu_valid,
  input  logic                            eu_ready,
  output logic [31:0]                     eu_rs1_v,
  output logic [31:0]                     eu_rs2_v,
  output logic [PREG_IDX_W-1:0]           eu_prd_s,
  output logic [ROB_IDX_W-1:0]            eu_rob_id,
  output logic [EBR_MASK_SIZE-1:0]        eu_ebr_mask,
  output logic [PAYLOAD_W-1:0]            eu_payload
);

  typedef struct packed {
    logic                     vld;
    logic [31:0]              rs1;
    logic [31:0]              rs2;
    logic [PREG_IDX_W-1:0]    prd;
    logic [ROB_IDX_W-1:0]     rob;
    logic [EBR_MASK_SIZE-1:0] mask;
    logic [PAYLOAD_W-1:0]     payload;
  } slot_t;

  slot_t [1:0] slot_q, slot_d;
  slot_t       s0, s1, inc;
  logic [31:0] op1, op2;
  logic        hit1, hit2;
  logic [EBR_MASK_SIZE-1:0] clr_mask;
  logic        bra_kill, kill0, kill1, in_kill;
  logic        accept, pop, surv0, surv1, in_ok;

  assign rf_rs1_addr = iq_prs1_s;
  assign rf_rs2_addr = iq_prs2_s;

  // Registered-only: slot1 never holds an entry unless slot0 does.
  assign iq_ready = !(slot_q[0].vld && slot_q[1].vld);
  assign accept   = iq_valid && iq_ready;

  // Lowest CDB port wins; p0 is hardwired zero regardless of bypass.
  always_comb begin
    op1  = rf_rs1_data;
    op2  = rf_rs2_data;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int j = 0; j < CDB_WIDTH; j++) begin
      if (!hit1 && cdb_valid[j] && cdb_prd_s[j*PREG_IDX_W +: PREG_IDX_W] == iq_prs1_s) begin
        op1  = cdb_data[j*32 +: 32];
        hit1 = 1'b1;
      end
      if (!hit2 && cdb_valid[j] && cdb_prd_s[j*PREG_IDX_W +: PREG_IDX_W] == iq_prs2_s) begin
        op2  = cdb_data[j*32 +: 32];
        hit2 = 1'b1;
      end
    end
    if (iq_prs1_s == '0) op1 = '0;
    if (iq_prs2_s == '0) op2 = '0;
  end

  assign clr_mask = bra_done ? bra_id : '0;
  assign bra_kill = bra_done && bra_mispredict;
  assign kill0    = bra_kill && |(slot_q[0].mask & bra_id);
  assign kill1    = bra_kill && |(slot_q[1].mask & bra_id);
  assign in_kill  = bra_kill && |(iq_ebr_mask & bra_id);

  assign eu_valid    = slot_q[0].vld && !kill0;
  assign eu_rs1_v    = slot_q[0].rs1;
  assign eu_rs2_v    = slot_q[0].rs2;
  assign eu_prd_s    = slot_q[0].prd;
  assign eu_rob_id   = slot_q[0].rob;
  assign eu_ebr_mask = slot_q[0].mask & ~clr_mask;
  assign eu_payload  = slot_q[0].payload;

  assign pop   = eu_valid && eu_ready;
  assign surv0 = slot_q[0].vld && !kill0 && !pop;
  assign surv1 = slot_q[1].vld && !kill1;
  assign in_ok = accept && !in_kill;

  always_comb begin
    s0      = slot_q[0];
    s0.mask = slot_q[0].mask & ~clr_mask;
    s1      = slot_q[1];
    s1.mask = slot_q[1].mask & ~clr_mask;
    inc     = '{vld: 1'b1, rs1: op1, rs2: op2, prd: iq_prd_s, rob: iq_rob_id,
                mask: iq_ebr_mask & ~clr_mask, payload: iq_payload};

    slot_d[0]     = s0;
    slot_d[0].vld = 1'b0;
    slot_d[1]     = s1;
    slot_d[1].vld = 1'b0;

    // Compact survivors in age order, then append the incoming entry.
    if (surv0)      slot_d[0] = s0;
    else if (surv1) slot_d[0] = s1;
    else if (in_ok) slot_d[0] = inc;

    if (surv0 && surv1)               slot_d[1] = s1;
    else if ((surv0 || surv1) && in_ok) slot_d[1] = inc;

    if (late_flush) begin
      slot_d[0].vld = 1'b0;
      slot_d[1].vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

endmodule

// File: tb/tb_issue_reg_read.sv
// Directed bench for issue_reg_read: bypass, backpressure, branch kill/clear, flush, reset.
module tb_issue_reg_read;
  localparam int PW = 6, RW = 5, MW = 4, CW = 2, DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic iq_valid, iq_ready;
  logic [PW-1:0] iq_prs1_s, iq_prs2_s, iq_prd_s;
  logic [RW-1:0] iq_rob_id;
  logic [MW-1:0] iq_ebr_mask;
  logic [DW-1:0] iq_payload;
  logic [PW-1:0] rf_rs1_addr, rf_rs2_addr;
  logic [31:0]   rf_rs1_data, rf_rs2_data;
  logic [CW-1:0] cdb_valid;
  logic [CW*PW-1:0] cdb_prd_s;
  logic [CW*32-1:0] cdb_data;
  logic bra_done, bra_mispredict, late_flush;
  logic [MW-1:0] bra_id;
  logic eu_valid, eu_ready;
  logic [31:0] eu_rs1_v, eu_rs2_v;
  logic [PW-1:0] eu_prd_s;
  logic [RW-1:0] eu_rob_id;
  logic [MW-1:0] eu_ebr_mask;
  logic [DW-1:0] eu_payload;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  issue_reg_read dut (
    .clk(clk), .rst(rst), .iq_valid(iq_valid), .iq_ready(iq_ready),
    .iq_prs1_s(iq_prs1_s), .iq_prs2_s(iq_prs2_s), .iq_prd_s(iq_prd_s),
    .iq_rob_id(iq_rob_id), .iq_ebr_mask(iq_ebr_mask), .iq_payload(iq_payload),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .cdb_valid(cdb_valid), .cdb_prd_s(cdb_prd_s), .cdb_data(cdb_data),
    .bra_done(bra_done), .bra_mispredict(bra_mispredict), .bra_id(bra_id),
    .late_flush(late_flush), .eu_valid(eu_valid), .eu_ready(eu_ready),
    .eu_rs1_v(eu_rs1_v), .eu_rs2_v(eu_rs2_v), .eu_prd_s(eu_prd_s),
    .eu_rob_id(eu_rob_id), .eu_ebr_mask(eu_ebr_mask), .eu_payload(eu_payload)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; iq_valid = 1'b0; iq_prs1_s = '0; iq_prs2_s = '0; iq_prd_s = '0;
    iq_rob_id = '0; iq_ebr_mask = '0; iq_payload = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; cdb_valid = '0; cdb_prd_s = '0; cdb_data = '0;
    bra_done = 1'b0; bra_mispredict = 1'b0; bra_id = '0; late_flush = 1'b0;
  endtask

  // Inputs change at negedge; one rising edge; back at next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] pl, input logic [MW-1:0] m);
    iq_valid = 1'b1; iq_prs1_s = 6'd1; iq_prs2_s = 6'd2; iq_payload = pl; iq_ebr_mask = m;
    rf_rs1_data = 32'h1; rf_rs2_data = 32'h2;
    step();
    iq_valid = 1'b0;
  endtask

  initial begin
    idle();
    eu_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    chk("rst_eu_valid", 64'(eu_valid), 64'd0);
    chk("rst_iq_ready", 64'(iq_ready), 64'd1);

    // rf read, p0 reads zero, pass-through fields
    iq_valid = 1'b1; iq_prs1_s = 6'd5; iq_prs2_s = 6'd0; rf_rs1_data = 32'h11;
    rf_rs2_data = 32'h99; iq_prd_s = 6'd12; iq_rob_id = 5'd17; iq_payload = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("rf_addr1", 64'(rf_rs1_addr), 64'd5);
    chk("rf_addr2", 64'(rf_rs2_addr), 64'd0);
    step();
    idle();
    #1;
    chk("t1_eu_valid", 64'(eu_valid), 64'd1);
    chk("t1_rs1", 64'(eu_rs1_v), 64'h11);
    chk("t1_rs2", 64'(eu_rs2_v), 64'h0);
    chk("t1_prd", 64'(eu_prd_s), 64'd12);
    chk("t1_rob", 64'(eu_rob_id), 64'd17);
    chk("t1_payload", eu_payload, 64'hDEAD_BEEF_0123_4567);
    eu_ready = 1'b1;
    step();
    chk("t1_drained", 64'(eu_valid), 64'd0);

    // CDB bypass, both ports match: port 0 wins
    iq_valid = 1'b1; iq_prs1_s = 6'd7; iq_prs2_s = 6'd3; rf_rs1_data = 32'h0; rf_rs2_data = 32'h33;
    cdb_valid = 2'b11; cdb_prd_s = {6'd7, 6'd7}; cdb_data = {32'hB, 32'hA};
    step();
    idle();
    chk("t2_rs1_cdb0", 64'(eu_rs1_v), 64'hA);
    chk("t2_rs2_rf", 64'(eu_rs2_v), 64'h33);
    // only port 1 valid; p0 ignores a CDB match on index 0; throughput 1/cycle
    iq_valid = 1'b1; iq_prs1_s = 6'd9; iq_prs2_s = 6'd0; rf_rs1_data = 32'h1;
    cdb_valid = 2'b10; cdb_prd_s = {6'd9, 6'd9}; cdb_data = {32'hD, 32'hC};
    #1;
    chk("t2_pop_iq_ready", 64'(iq_ready), 64'd1);
    step();
    cdb_valid = 2'b11; cdb_prd_s = {6'd0, 6'd0}; cdb_data = {32'h77, 32'h66};
    iq_prs1_s = 6'd0; iq_prs2_s = 6'd0;
    #1;
    chk("t2_rs1_cdb1", 64'(eu_rs1_v), 64'hD);
    step();
    idle();
    chk("t2_p0_zero_rs1", 64'(eu_rs1_v), 64'h0);
    chk("t2_p0_zero_rs2", 64'(eu_rs2_v), 64'h0);
    step();
    chk("t2_drained", 64'(eu_valid), 64'd0);

    // backpressure: two accepted, third refused, in-order drain
    eu_ready = 1'b0;
    push(64'd1, '0);
    push(64'd2, '0);
    iq_valid = 1'b1; iq_payload = 64'd3;
    #1;
    chk("t3_full_iq_ready", 64'(iq_ready), 64'd0);
    step();
    idle();
    chk("t3_held_valid", 64'(eu_valid), 64'd1);
    chk("t3_held_payload", eu_payload, 64'd1);
    eu_ready = 1'b1;
    step();
    chk("t3_drain2", eu_payload, 64'd2);
    chk("t3_drain2_valid", 64'(eu_valid), 64'd1);
    step();
    chk("t3_empty", 64'(eu_valid), 64'd0);

    // mispredict kills slot0, slot1 advances
    eu_ready = 1'b0;
    push(64'd20, 4'b0010);
    push(64'd21, 4'b0000);
    bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0010;
    #1;
    chk("t4_kill_eu_valid", 64'(eu_valid), 64'd0);
    step();
    idle();
    chk("t4_survivor_valid", 64'(eu_valid), 64'd1);
    chk("t4_survivor_payload", eu_payload, 64'd21);
    chk("t4_iq_ready", 64'(iq_ready), 64'd1);
    eu_ready = 1'b1;
    step();
    // incoming entry killed on accept
    iq_valid = 1'b1; iq_ebr_mask = 4'b1000; bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b1000;
    step();
    idle();
    chk("t4_in_killed", 64'(eu_valid), 64'd0);

    // correct prediction clears the bit, same cycle and stored
    eu_ready = 1'b0;
    push(64'd30, 4'b0110);
    bra_done = 1'b1; bra_id = 4'b0100;
    #1;
    chk("t5_mask_now", 64'(eu_ebr_mask), 64'b0010);
    chk("t5_valid_now", 64'(eu_valid), 64'd1);
    step();
    idle();
    chk("t5_mask_stored", 64'(eu_ebr_mask), 64'b0010);
    eu_ready = 1'b1;
    step();

    // late flush with full buffer and pending accept
    eu_ready = 1'b0;
    push(64'd40, '0);
    push(64'd41, '0);
    iq_valid = 1'b1; late_flush = 1'b1; eu_ready = 1'b1;
    #1;
    chk("t6_preflush_valid", 64'(eu_valid), 64'd1);
    step();
    idle();
    chk("t6_flush_valid", 64'(eu_valid), 64'd0);
    chk("t6_flush_ready", 64'(iq_ready), 64'd1);

    // reset mid-stream
    eu_ready = 1'b0;
    push(64'd50, '0);
    push(64'd51, '0);
    rst = 1'b1; iq_valid = 1'b1;
    step();
    idle();
    chk("t6_rst_valid", 64'(eu_valid), 64'd0);
    chk("t6_rst_ready", 64'(iq_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
